// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: default width and
// FSM state encoding.
package div_pkg;

   localparam int DIV_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits.
module div_restore_step #(
   parameter int W = 8
) (
   input  logic [W-1:0] p,
   input  logic         nbit,
   input  logic [W-1:0] d,
   output logic [W-1:0] p_next,
   output logic         q_bit
);

   logic [W:0] t;

   // p < d on entry, so t < 2*d and t - d always fits back into W bits.
   always_comb begin
      t      = {p, nbit};
      q_bit  = (t >= {1'b0, d});
      p_next = q_bit ? (t[W-1:0] - d) : t[W-1:0];
   end

endmodule

// File: rtl/div_16x8_seq.sv
// Sequential restoring divider, 2W-bit dividend by W-bit divisor, one quotient
// bit per clock, valid/ready on both sides with one operation in flight.
module div_16x8_seq
   import div_pkg::*;
#(
   parameter int W = DIV_W
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [2*W-1:0] N,
   input  logic [W-1:0]   D,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [W-1:0]   Q,
   output logic [W-1:0]   REM,
   output logic           OVF,
   output logic           DIVZ,
   output logic           out_valid,
   input  logic           out_ready
);

   localparam int CW = $clog2(W + 1);

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [W-1:0]    p;
   logic [W-1:0]    s;
   logic [W-1:0]    dr;
   logic [W-1:0]    p_nxt;
   logic            qbit;
   logic            accept;

   assign accept = in_valid && in_ready;

   div_restore_step #(.W(W)) u_step (
      .p      (p),
      .nbit   (s[W-1]),
      .d      (dr),
      .p_next (p_nxt),
      .q_bit  (qbit)
   );

   // Datapath: s holds the remaining dividend bits in its top and collects
   // quotient bits in its bottom, so after W shifts it is the quotient.
   always_ff @(posedge clk) begin
      if (accept) begin
         p  <= N[2*W-1:W];
         s  <= N[W-1:0];
         dr <= D;
      end else if (state == CALC) begin
         p <= p_nxt;
         s <= {s[W-2:0], qbit};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         Q         <= '0;
         REM       <= '0;
         OVF       <= 1'b0;
         DIVZ      <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  in_ready <= 1'b0;
                  if (D == '0) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     DIVZ      <= 1'b1;
                     OVF       <= 1'b0;
                     Q         <= '1;
                     REM       <= N[W-1:0];
                  end else if (N[2*W-1:W] >= D) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     DIVZ      <= 1'b0;
                     OVF       <= 1'b1;
                     Q         <= '1;
                     REM       <= '0;
                  end else begin
                     state <= CALC;
                     DIVZ  <= 1'b0;
                     OVF   <= 1'b0;
                     cnt   <= CW'(W);
                  end
               end
            end
            CALC: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  Q         <= {s[W-2:0], qbit};
                  REM       <= p_nxt;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_16x8_seq.sv
// Self-checking bench for div_16x8_seq: cycle-level behavioural model plus
// directed cases with literal expectations and a randomised sweep.
module tb_div_16x8_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] N = '0;
   logic [7:0]  D = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  Q;
   logic [7:0]  REM;
   logic        OVF;
   logic        DIVZ;
   logic        out_valid;
   logic        out_ready = 1'b1;

   int checks = 0;
   int failures = 0;

   div_16x8_seq #(.W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .N         (N),
      .D         (D),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Q         (Q),
      .REM       (REM),
      .OVF       (OVF),
      .DIVZ      (DIVZ),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer division; quotient over 255 means overflow.
   function automatic void ref_div(input logic [15:0] n, input logic [7:0] d,
                                   output logic [7:0] q, output logic [7:0] r,
                                   output logic ovf, output logic divz, output int lat);
      int qi;
      int ri;
      ovf = 1'b0;
      divz = 1'b0;
      lat = 1;
      if (d == 8'd0) begin
         divz = 1'b1;
         q = 8'hFF;
         r = n[7:0];
      end else if (int'(n) / int'(d) > 255) begin
         ovf = 1'b1;
         q = 8'hFF;
         r = 8'h00;
      end else begin
         qi = int'(n) / int'(d);
         ri = int'(n) % int'(d);
         q = qi[7:0];
         r = ri[7:0];
         lat = 8;
      end
   endfunction

   // Model state, advanced on each rising edge using pre-edge input values.
   int          cyc = 0;
   bit          busy = 1'b0;
   int          ready_at = 0;
   logic [7:0]  e_q, e_r;
   logic        e_ovf, e_divz;
   logic [15:0] e_n;
   logic [7:0]  e_d;
   bit          mon_en = 1'b0;

   initial forever begin
      int lat;
      @(posedge clk);
      cyc++;
      if (rst) begin
         busy = 1'b0;
      end else if (busy) begin
         if ((cyc - 1) >= ready_at && out_ready) busy = 1'b0;
      end else if (in_valid) begin
         ref_div(N, D, e_q, e_r, e_ovf, e_divz, lat);
         e_n = N;
         e_d = D;
         busy = 1'b1;
         ready_at = cyc + lat - 1 + ((lat == 1) ? 0 : 1);
      end
   end

   initial forever begin
      bit exp_ov;
      @(negedge clk);
      if (mon_en && !rst) begin
         exp_ov = busy && (cyc >= ready_at);
         chk("mon_in_ready", 32'(in_ready), 32'(!busy));
         chk("mon_out_valid", 32'(out_valid), 32'(exp_ov));
         if (exp_ov && out_valid) begin
            chk("mon_q", 32'(Q), 32'(e_q));
            chk("mon_rem", 32'(REM), 32'(e_r));
            chk("mon_ovf", 32'(OVF), 32'(e_ovf));
            chk("mon_divz", 32'(DIVZ), 32'(e_divz));
            if (!e_ovf && !e_divz) begin
               chk("mon_q_times_d_plus_rem", 32'(int'(Q) * int'(e_d) + int'(REM)), 32'(e_n));
               chk("mon_rem_lt_d", 32'(REM < e_d), 32'd1);
            end
         end
      end
   end

   task automatic issue(input logic [15:0] n, input logic [7:0] d, input bit rnd);
      int t = 0;
      while (!in_ready && t < 300) begin
         @(negedge clk);
         t++;
         if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      end
      chk("in_ready_before_issue", 32'(in_ready), 32'd1);
      N = n;
      D = d;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input int bound);
      int t = 0;
      while (!out_valid && t < bound) begin
         @(negedge clk);
         t++;
      end
      chk("wait_out_valid", 32'(out_valid), 32'd1);
   endtask

   task automatic expect_result(input string tag, input logic [7:0] q, input logic [7:0] r,
                                input logic ovf, input logic divz);
      chk({tag, "_q"}, 32'(Q), 32'(q));
      chk({tag, "_rem"}, 32'(REM), 32'(r));
      chk({tag, "_ovf"}, 32'(OVF), 32'(ovf));
      chk({tag, "_divz"}, 32'(DIVZ), 32'(divz));
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] mq, mr;
      logic       mo, mz;
      int         ml;
      logic [7:0] rd, hi;

      // Pin the reference model itself.
      ref_div(16'h1E61, 8'h7B, mq, mr, mo, mz, ml);
      chk("model_7777_q", 32'(mq), 32'h3F);
      chk("model_7777_rem", 32'(mr), 32'h1C);
      chk("model_7777_lat", 32'(ml), 32'd8);
      ref_div(16'h1234, 8'h00, mq, mr, mo, mz, ml);
      chk("model_divz_rem", 32'(mr), 32'h34);
      chk("model_divz_flag", 32'(mz), 32'd1);
      ref_div(16'h1000, 8'h10, mq, mr, mo, mz, ml);
      chk("model_ovf_flag", 32'(mo), 32'd1);

      repeat (3) @(negedge clk);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      expect_result("reset", 8'h00, 8'h00, 1'b0, 1'b0);
      rst = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);

      // Basic division with immediate consumption.
      out_ready = 1'b1;
      issue(16'h1E61, 8'h7B, 1'b0);
      wait_valid(20);
      expect_result("d7777", 8'h3F, 8'h1C, 1'b0, 1'b0);
      @(negedge clk);
      chk("d7777_in_ready_after", 32'(in_ready), 32'd1);
      chk("d7777_out_valid_after", 32'(out_valid), 32'd0);

      issue(16'hFE01, 8'hFF, 1'b0);
      wait_valid(20);
      expect_result("d255sq", 8'hFF, 8'h00, 1'b0, 1'b0);
      issue(16'h00FE, 8'h07, 1'b0);
      wait_valid(20);
      expect_result("d254", 8'h24, 8'h02, 1'b0, 1'b0);

      // Overflow and divide-by-zero complete on the accepting edge.
      issue(16'h1000, 8'h10, 1'b0);
      chk("ovf_immediate_valid", 32'(out_valid), 32'd1);
      expect_result("ovf", 8'hFF, 8'h00, 1'b1, 1'b0);
      issue(16'h1234, 8'h00, 1'b0);
      chk("divz_immediate_valid", 32'(out_valid), 32'd1);
      expect_result("divz", 8'hFF, 8'h34, 1'b0, 1'b1);

      // Output stall with an ignored in_valid pulse.
      @(negedge clk);
      out_ready = 1'b0;
      issue(16'h1E61, 8'h7B, 1'b0);
      wait_valid(20);
      for (int i = 0; i < 5; i++) begin
         chk("stall_q", 32'(Q), 32'h3F);
         chk("stall_rem", 32'(REM), 32'h1C);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         if (i == 1) begin
            N = 16'h0001;
            D = 8'h01;
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("stall_q_final", 32'(Q), 32'h3F);
      out_ready = 1'b1;
      @(negedge clk);
      chk("stall_consumed_valid", 32'(out_valid), 32'd0);
      chk("stall_consumed_in_ready", 32'(in_ready), 32'd1);

      // Asynchronous abort mid-calculation.
      issue(16'h1E61, 8'h7B, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      expect_result("abort", 8'h00, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      issue(16'h0064, 8'h0A, 1'b0);
      wait_valid(20);
      expect_result("after_abort", 8'h0A, 8'h00, 1'b0, 1'b0);

      // Randomised sweep; mostly in-range operands, occasionally anything.
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 15) == 0) begin
            hi = 8'($urandom_range(0, 255));
            rd = 8'($urandom_range(0, 255));
         end else begin
            rd = 8'($urandom_range(1, 255));
            hi = 8'($urandom_range(0, int'(rd) - 1));
         end
         issue({hi, 8'($urandom_range(0, 255))}, rd, 1'b1);
         out_ready = ($urandom_range(0, 3) != 0);
      end

      out_ready = 1'b1;
      for (int t = 0; t < 30 && !in_ready; t++) @(negedge clk);
      chk("drain_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      mon_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
